sync_fifo_pf: RTL and testbench
===============================

// Module: sync_fifo_pf
// PURPOSE
// - Parametrised single-clock FIFO; successor to the basic sync FIFO.
// - Adds occupancy count, programmable almost-full/almost-empty flags, full flag,
//   sticky overflow/underflow errors and a registered read port.
// - Elastic buffer between same-clock producer/consumer blocks.
// PARAMETERS
// - WID       16  data width in bits
// - DEP_LOG2  4   log2 of depth; DEPTH = 2**DEP_LOG2 entries (DEP_LOG2 >= 1)
// PORTS
// - clk           in   1           clock, rising edge
// - rst           in   1           async reset, active-high
// - wr_i          in   1           write request
// - wdata         in   WID         write data
// - rd_i          in   1           read request (pop)
// - rdata         out  WID         read data
// - rvalid_o      out  1           rdata valid
// - full_o        out  1           FIFO holds DEPTH entries
// - empty_o       out  1           FIFO holds 0 entries
// - count_o       out  DEP_LOG2+1  occupancy, 0..DEPTH
// - afull_thr_i   in   DEP_LOG2+1  almost-full threshold
// - aempty_thr_i  in   DEP_LOG2+1  almost-empty threshold
// - afull_o       out  1           registered: count >= afull_thr_i
// - aempty_o      out  1           registered: count <= aempty_thr_i
// - ovf_o         out  1           sticky: write attempted while full
// - udf_o         out  1           sticky: read attempted while empty
// - clr_err_i     in   1           clears ovf_o/udf_o
// BEHAVIOUR
// - Single clock clk; rst is asynchronous, active-high.
// - Reset values: pointers 0, count_o 0, empty_o 1, full_o 0, afull_o 0,
//   aempty_o 1, ovf_o 0, udf_o 0, rvalid_o 0, rdata 0. Storage array is not reset.
// - Pointers are DEP_LOG2+1 bits. empty = (wp == rp).
//   full = MSBs differ and lower DEP_LOG2 bits equal.
// - Wrap-around is natural modulo 2**(DEP_LOG2+1).
// - count_o = wp - rp, registered, truncated to DEP_LOG2+1 bits.
// - Write accepted (wr_ok) = wr_i & ~full_o: stores wdata at wp, then wp++.
// - Read accepted (rd_ok) = rd_i & ~empty_o: rp++.
// - Acceptance is judged on current-cycle flags:
//   - at full, rd+wr same cycle: read accepted, write rejected (ovf set);
//   - at empty, rd+wr same cycle: write accepted, read rejected (udf set);
//   - otherwise simultaneous rd_ok/wr_ok leave count unchanged.
// - Read latency (default): rd_ok in cycle N gives rdata = entry[rp] and
//   rvalid_o = 1 in cycle N+1. rvalid_o = 0 the cycle after a non-accepted read;
//   rdata holds its last value.
// - afull_o/aempty_o are registered from next-state count against current
//   thresholds, so they are aligned with count_o.
//   - afull_thr_i = 0 gives afull_o = 1 from the first cycle after reset.
//   - Thresholds > DEPTH give afull_o = 0 always.
// - ovf_o set by wr_i & full_o; udf_o set by rd_i & empty_o.
//   Cleared by clr_err_i; set wins over clear in the same cycle.
// - Rejected operations never modify pointers, count or storage.
// - Reset asserted mid-operation: all state returns to reset values
//   asynchronously; stored data is discarded logically.
// CONFIGURATION
// - SYNC_FIFO_FWFT_EN defined: first-word-fall-through.
//   - rdata = entry[rp] combinationally; rvalid_o = ~empty_o.
//   - rd_i acts as acknowledge/pop: the next word appears the cycle after rd_ok.
//   - First write into an empty FIFO is visible on rdata in the cycle after it.
//   - rdata is don't-care while rvalid_o = 0.
// - SYNC_FIFO_FWFT_EN undefined: registered read, 1-cycle latency as above.
// TESTING
// - DEP_LOG2=4: after reset, check empty_o=1, aempty_o=1, count_o=0,
//   rvalid_o=0, ovf_o=0, udf_o=0.
// - Write 0x0000..0x000F, 16 cycles -> full_o=1, count_o=16, afull_o=1 with
//   afull_thr_i=12 from the cycle count reaches 12.
//   17th write 0xBEEF -> ovf_o=1, count stays 16.
// - Read 16 back-to-back -> rdata 0x0000..0x000F in order, one cycle after
//   each rd_i, 0xBEEF never seen. Then empty_o=1; an extra rd_i sets udf_o=1
//   and gives rvalid_o=0 next cycle. clr_err_i clears both.
// - count_o=8, rd_i=wr_i=1 for 40 cycles with incrementing data -> count_o
//   stays 8, pointers wrap twice, output order preserved. Repeat at full and
//   at empty for the edge-case acceptance rules.
// - Assert rst mid-burst at count_o=5 -> all outputs at reset values
//   immediately. After release, write 0xA5A5 and read -> 0xA5A5 returned,
//   no stale data.
// - SYNC_FIFO_FWFT_EN build: write 0x1234 to empty -> next cycle rvalid_o=1,
//   rdata=0x1234 with no rd_i. rd_i=1 -> next cycle rvalid_o=0.

Source files
------------

// File: rtl/sync_fifo_pf.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_pf
// Description : Parametrised single-clock FIFO with occupancy count,
//               programmable almost-full / almost-empty flags, full/empty
//               flags, sticky overflow/underflow errors and a registered
//               read port.
//               Optional build macro SYNC_FIFO_FWFT_EN selects a
//               first-word-fall-through read port instead of the
//               registered one.
// Ports       : clk, rst          clock (rising edge), async active-high reset
//               wr_i, wdata       write request and data
//               rd_i              read request (pop / acknowledge in FWFT)
//               rdata, rvalid_o   read data and its valid qualifier
//               full_o, empty_o   occupancy flags
//               count_o           occupancy 0..DEPTH
//               afull_thr_i       almost-full threshold  (afull_o  = count >= thr)
//               aempty_thr_i      almost-empty threshold (aempty_o = count <= thr)
//               ovf_o, udf_o      sticky overflow / underflow errors
//               clr_err_i         clears ovf_o / udf_o (set has priority)
// Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_pf #(
    parameter int WID      = 16,
    parameter int DEP_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_i,
    input  logic [WID-1:0]      wdata,
    input  logic                rd_i,
    output logic [WID-1:0]      rdata,
    output logic                rvalid_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [DEP_LOG2:0]   count_o,
    input  logic [DEP_LOG2:0]   afull_thr_i,
    input  logic [DEP_LOG2:0]   aempty_thr_i,
    output logic                afull_o,
    output logic                aempty_o,
    output logic                ovf_o,
    output logic                udf_o,
    input  logic                clr_err_i
);

    localparam int DEPTH = 2**DEP_LOG2;

    logic [WID-1:0]    mem_q [DEPTH];

    logic [DEP_LOG2:0] wp_q, wp_d;
    logic [DEP_LOG2:0] rp_q, rp_d;
    logic [DEP_LOG2:0] count_q, count_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              wr_ok;
    logic              rd_ok;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty_o = (wp_q == rp_q);
    assign full_o  = (wp_q[DEP_LOG2] != rp_q[DEP_LOG2]) &&
                     (wp_q[DEP_LOG2-1:0] == rp_q[DEP_LOG2-1:0]);

    // Acceptance uses this cycle's flags: at full a simultaneous read frees a
    // slot only for next cycle, so the write is still refused (and vice versa).
    assign wr_ok = wr_i & ~full_o;
    assign rd_ok = rd_i & ~empty_o;

    always_comb begin
        wp_d     = wp_q + {{DEP_LOG2{1'b0}}, wr_ok};
        rp_d     = rp_q + {{DEP_LOG2{1'b0}}, rd_ok};
        count_d  = wp_d - rp_d;
        // Flags are computed from the next count so they line up with count_o.
        afull_d  = (count_d >= afull_thr_i);
        aempty_d = (count_d <= aempty_thr_i);
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clr_err_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wr_i && full_o) begin
            ovf_d = 1'b1;
        end
        if (rd_i && empty_o) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q     <= '0;
            rp_q     <= '0;
            count_q  <= '0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately not reset; pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wp_q[DEP_LOG2-1:0]] <= wdata;
        end
    end

    assign count_o  = count_q;
    assign afull_o  = afull_q;
    assign aempty_o = aempty_q;
    assign ovf_o    = ovf_q;
    assign udf_o    = udf_q;

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry is presented directly; rd_i only advances the read pointer.
    assign rdata    = mem_q[rp_q[DEP_LOG2-1:0]];
    assign rvalid_o = ~empty_o;
`else
    logic [WID-1:0] rdata_q;
    logic           rvalid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_ok;
            if (rd_ok) begin
                rdata_q <= mem_q[rp_q[DEP_LOG2-1:0]];
            end
        end
    end

    assign rdata    = rdata_q;
    assign rvalid_o = rvalid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_pf.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_pf
// Description : Directed self-checking bench for sync_fifo_pf (DEP_LOG2=4,
//               WID=16). Covers reset values, fill/overflow, drain/underflow,
//               error clear priority, steady-state wrap with simultaneous
//               read/write, full/empty simultaneous-access rules, threshold
//               corners and asynchronous reset mid-burst. When built with
//               SYNC_FIFO_FWFT_EN it exercises the fall-through read port.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sync_fifo_pf;

    localparam int WID      = 16;
    localparam int DEP_LOG2 = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                wr_i = 1'b0;
    logic [WID-1:0]      wdata = '0;
    logic                rd_i = 1'b0;
    logic [WID-1:0]      rdata;
    logic                rvalid_o;
    logic                full_o;
    logic                empty_o;
    logic [DEP_LOG2:0]   count_o;
    logic [DEP_LOG2:0]   afull_thr_i = 5'd12;
    logic [DEP_LOG2:0]   aempty_thr_i = 5'd2;
    logic                afull_o;
    logic                aempty_o;
    logic                ovf_o;
    logic                udf_o;
    logic                clr_err_i = 1'b0;

    int total = 0;
    int bad   = 0;

    sync_fifo_pf #(.WID(WID), .DEP_LOG2(DEP_LOG2)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_i         (wr_i),
        .wdata        (wdata),
        .rd_i         (rd_i),
        .rdata        (rdata),
        .rvalid_o     (rvalid_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .count_o      (count_o),
        .afull_thr_i  (afull_thr_i),
        .aempty_thr_i (aempty_thr_i),
        .afull_o      (afull_o),
        .aempty_o     (aempty_o),
        .ovf_o        (ovf_o),
        .udf_o        (udf_o),
        .clr_err_i    (clr_err_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset ----------------
        step();
        step();
        chk("rst_empty",  32'(empty_o),  32'd1);
        chk("rst_full",   32'(full_o),   32'd0);
        chk("rst_aempty", 32'(aempty_o), 32'd1);
        chk("rst_afull",  32'(afull_o),  32'd0);
        chk("rst_count",  32'(count_o),  32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_ovf",    32'(ovf_o),    32'd0);
        chk("rst_udf",    32'(udf_o),    32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("rst_rdata",  32'(rdata),    32'd0);
`endif
        rst = 1'b0;
        // Zero almost-full threshold: flag asserts on the first active cycle.
        afull_thr_i = 5'd0;
        step();
        chk("thr0_afull", 32'(afull_o), 32'd1);
        afull_thr_i = 5'd12;
        step();
        chk("thr12_afull_empty", 32'(afull_o), 32'd0);

`ifdef SYNC_FIFO_FWFT_EN
        // ---------------- fall-through read port ----------------
        wr_i = 1'b1; wdata = 16'h1234;
        step();
        wr_i = 1'b0;
        chk("fwft_rvalid1", 32'(rvalid_o), 32'd1);
        chk("fwft_rdata1",  32'(rdata),    32'h1234);
        step();
        chk("fwft_hold",    32'(rdata),    32'h1234);
        rd_i = 1'b1;
        step();
        rd_i = 1'b0;
        chk("fwft_rvalid0", 32'(rvalid_o), 32'd0);
        chk("fwft_empty",   32'(empty_o),  32'd1);
        wr_i = 1'b1; wdata = 16'h00AA;
        step();
        wdata = 16'h00BB;
        step();
        wr_i = 1'b0;
        chk("fwft_head_a", 32'(rdata), 32'h00AA);
        rd_i = 1'b1;
        step();
        chk("fwft_head_b", 32'(rdata), 32'h00BB);
        chk("fwft_rv_b",   32'(rvalid_o), 32'd1);
        step();
        rd_i = 1'b0;
        chk("fwft_drained", 32'(rvalid_o), 32'd0);
        chk("fwft_count0",  32'(count_o),  32'd0);
`else
        // ---------------- fill 16 ----------------
        for (int i = 0; i < 16; i++) begin
            wr_i = 1'b1; wdata = 16'(i);
            step();
            chk("fill_count",  32'(count_o),  32'(i + 1));
            chk("fill_afull",  32'(afull_o),  32'((i + 1) >= 12));
            chk("fill_aempty", 32'(aempty_o), 32'((i + 1) <= 2));
        end
        chk("fill_full", 32'(full_o), 32'd1);
        // 17th write is refused
        wdata = 16'hBEEF;
        step();
        wr_i = 1'b0;
        chk("ovf_set",   32'(ovf_o),   32'd1);
        chk("ovf_count", 32'(count_o), 32'd16);
        // Threshold above depth never asserts
        afull_thr_i = 5'd17;
        step();
        chk("thr17_afull", 32'(afull_o), 32'd0);
        afull_thr_i = 5'd12;

        // ---------------- drain 16 ----------------
        for (int i = 0; i < 16; i++) begin
            rd_i = 1'b1;
            step();
            chk("drain_rvalid", 32'(rvalid_o), 32'd1);
            chk("drain_rdata",  32'(rdata),    32'(i));
        end
        rd_i = 1'b0;
        chk("drain_empty", 32'(empty_o), 32'd1);
        chk("drain_count", 32'(count_o), 32'd0);
        rd_i = 1'b1;
        step();
        rd_i = 1'b0;
        chk("udf_set",     32'(udf_o),    32'd1);
        chk("udf_rvalid",  32'(rvalid_o), 32'd0);
        chk("udf_rdhold",  32'(rdata),    32'h000F);
        // Set beats clear in the same cycle
        rd_i = 1'b1; clr_err_i = 1'b1;
        step();
        rd_i = 1'b0;
        chk("setwins_udf", 32'(udf_o), 32'd1);
        chk("clr_ovf",     32'(ovf_o), 32'd0);
        step();
        clr_err_i = 1'b0;
        chk("clr_udf", 32'(udf_o), 32'd0);

        // ---------------- steady state at count 8, 40 cycles ----------------
        for (int i = 0; i < 8; i++) begin
            wr_i = 1'b1; wdata = 16'h0100 + 16'(i);
            step();
        end
        chk("mid_count", 32'(count_o), 32'd8);
        for (int i = 0; i < 40; i++) begin
            wr_i = 1'b1; rd_i = 1'b1; wdata = 16'h0108 + 16'(i);
            step();
            chk("wrap_rdata",  32'(rdata),    32'h0100 + 32'(i));
            chk("wrap_rvalid", 32'(rvalid_o), 32'd1);
            chk("wrap_count",  32'(count_o),  32'd8);
        end
        rd_i = 1'b0;
        // Holds 0x128..0x12F; top up to full with 0x130..0x137
        for (int i = 0; i < 8; i++) begin
            wr_i = 1'b1; wdata = 16'h0130 + 16'(i);
            step();
        end
        chk("full2_full", 32'(full_o), 32'd1);

        // ---------------- simultaneous access at full ----------------
        wr_i = 1'b1; rd_i = 1'b1; wdata = 16'hDEAD;
        step();
        wr_i = 1'b0; rd_i = 1'b0;
        chk("atfull_rdata", 32'(rdata),   32'h0128);
        chk("atfull_count", 32'(count_o), 32'd15);
        chk("atfull_ovf",   32'(ovf_o),   32'd1);
        clr_err_i = 1'b1;
        step();
        clr_err_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            rd_i = 1'b1;
            step();
            chk("drain2_rdata", 32'(rdata), 32'h0129 + 32'(i));
        end
        rd_i = 1'b0;
        chk("drain2_empty", 32'(empty_o), 32'd1);

        // ---------------- simultaneous access at empty ----------------
        wr_i = 1'b1; rd_i = 1'b1; wdata = 16'h5555;
        step();
        wr_i = 1'b0; rd_i = 1'b0;
        chk("atempty_count",  32'(count_o),  32'd1);
        chk("atempty_udf",    32'(udf_o),    32'd1);
        chk("atempty_rvalid", 32'(rvalid_o), 32'd0);
        rd_i = 1'b1; clr_err_i = 1'b1;
        step();
        rd_i = 1'b0; clr_err_i = 1'b0;
        chk("atempty_rdata", 32'(rdata),   32'h5555);
        chk("atempty_clr",   32'(udf_o),   32'd0);

        // ---------------- async reset mid-burst ----------------
        for (int i = 0; i < 5; i++) begin
            wr_i = 1'b1; wdata = 16'h0700 + 16'(i);
            step();
        end
        chk("pre_rst_count", 32'(count_o), 32'd5);
        rd_i = 1'b1;
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst_count",  32'(count_o),  32'd0);
        chk("arst_empty",  32'(empty_o),  32'd1);
        chk("arst_rvalid", 32'(rvalid_o), 32'd0);
        chk("arst_rdata",  32'(rdata),    32'd0);
        chk("arst_aempty", 32'(aempty_o), 32'd1);
        wr_i = 1'b0; rd_i = 1'b0;
        step();
        rst = 1'b0;
        step();
        wr_i = 1'b1; wdata = 16'hA5A5;
        step();
        wr_i = 1'b0;
        chk("post_count", 32'(count_o), 32'd1);
        rd_i = 1'b1;
        step();
        rd_i = 1'b0;
        chk("post_rdata",  32'(rdata),    32'hA5A5);
        chk("post_rvalid", 32'(rvalid_o), 32'd1);
        chk("post_empty",  32'(empty_o),  32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
